// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, writeback and execute-facing bundle of the RV32I decode stage
//
// Purpose: groups every decode-stage signal except clk/rst.
// Ports (modport slave = decode stage, master = its environment):
//   fetch in : instr_in, pc_in, instr_valid, flush
//   wb in    : wb_en, wb_rd, wb_data
//   out      : hazard_stall (combinational), id_* (registered, to execute)
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] pc_in;
    logic            instr_valid;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            hazard_stall;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_funct3;
    logic [3:0]      id_alu_op;
    logic            id_alu_src_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_branch;
    logic            id_jal;
    logic            id_jalr;
    logic            id_auipc;
    logic            id_illegal;

    modport master (
        output instr_in, pc_in, instr_valid, flush, wb_en, wb_rd, wb_data,
        input  hazard_stall, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_alu_op,
               id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write,
               id_branch, id_jal, id_jalr, id_auipc, id_illegal
    );

    modport slave (
        input  instr_in, pc_in, instr_valid, flush, wb_en, wb_rd, wb_data,
        output hazard_stall, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_alu_op,
               id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write,
               id_branch, id_jal, id_jalr, id_auipc, id_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with owned register file and load-use detection
//
// Purpose: registers and decodes the fetched instruction, reads the 32x32
// register file (written by writeback, write-first bypass on reads), detects
// load-use hazards against the instruction currently held in the output register.
// Ports: clk, rst (async active-low), bus (decode_stage_if.slave).
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_FENCE = 7'b0001111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            alu_src_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            auipc;
        logic            illegal;
    } id_t;

    logic [XLEN-1:0] rf_q [32];
    id_t             id_q;
    id_t             id_d;
    id_t             dec;
    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic            use_rs1;
    logic            use_rs2;
    logic            stall;

    // funct3 -> ALU op; alt selects SUB/SRA (bit 30)
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_from_f3 = ALU_SLL;
            3'd2:    alu_from_f3 = ALU_SLT;
            3'd3:    alu_from_f3 = ALU_SLTU;
            3'd4:    alu_from_f3 = ALU_XOR;
            3'd5:    alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    // Write-first read: a same-cycle writeback wins over the stored value
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0)
            rf_read = '0;
        else if (bus.wb_en && bus.wb_rd == idx)
            rf_read = bus.wb_data;
        else
            rf_read = rf_q[idx];
    endfunction

    assign instr  = bus.instr_in;
    assign opcode = instr[6:0];

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = bus.pc_in;
        dec.rd       = instr[11:7];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.funct3   = instr[14:12];
        dec.rs1_data = rf_read(instr[19:15]);
        dec.rs2_data = rf_read(instr[24:20]);
        case (opcode)
            OPC_LUI: begin
                dec.imm = {instr[31:12], 12'b0};
                dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm = {instr[31:12], 12'b0};
                dec.alu_src_imm = 1'b1; dec.auipc = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                dec.jal = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.imm = {{20{instr[31]}}, instr[31:20]};
                dec.jalr = 1'b1; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                dec.branch = 1'b1; dec.alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                dec.imm = {{20{instr[31]}}, instr[31:20]};
                dec.mem_read = 1'b1; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
            end
            OPC_OPIMM: begin
                dec.imm = {{20{instr[31]}}, instr[31:20]};
                // bit 30 only distinguishes SRAI; ADDI with a negative imm is not SUB
                dec.alu_op = alu_from_f3(instr[14:12], (instr[14:12] == 3'd5) && instr[30]);
                dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_OP: begin
                dec.alu_op = alu_from_f3(instr[14:12], instr[30]);
                dec.reg_write = 1'b1;
            end
            OPC_FENCE: ;
            default: dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0)
            dec.reg_write = 1'b0;
    end

    assign use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign stall = id_q.valid && id_q.mem_read && (id_q.rd != 5'd0) && bus.instr_valid && !bus.flush
                   && ((use_rs1 && id_q.rd == instr[19:15]) || (use_rs2 && id_q.rd == instr[24:20]));

    assign id_d = (bus.instr_valid && !bus.flush && !stall) ? dec : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            id_q <= id_d;
            if (bus.wb_en && bus.wb_rd != 5'd0)
                rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.hazard_stall   = stall;
    assign bus.id_valid       = id_q.valid;
    assign bus.id_pc          = id_q.pc;
    assign bus.id_rs1         = id_q.rs1;
    assign bus.id_rs2         = id_q.rs2;
    assign bus.id_rd          = id_q.rd;
    assign bus.id_rs1_data    = id_q.rs1_data;
    assign bus.id_rs2_data    = id_q.rs2_data;
    assign bus.id_imm         = id_q.imm;
    assign bus.id_funct3      = id_q.funct3;
    assign bus.id_alu_op      = id_q.alu_op;
    assign bus.id_alu_src_imm = id_q.alu_src_imm;
    assign bus.id_reg_write   = id_q.reg_write;
    assign bus.id_mem_read    = id_q.mem_read;
    assign bus.id_mem_write   = id_q.mem_write;
    assign bus.id_branch      = id_q.branch;
    assign bus.id_jal         = id_q.jal;
    assign bus.id_jalr        = id_q.jalr;
    assign bus.id_auipc       = id_q.auipc;
    assign bus.id_illegal     = id_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    // flags: {alu_src_imm, reg_write, mem_read, mem_write, branch, jal, jalr, auipc, illegal}
    localparam logic [8:0] F_IMM = 9'b100000000, F_RW = 9'b010000000, F_MR = 9'b001000000,
                           F_BR = 9'b000010000, F_ILL = 9'b000000001;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic [8:0]  fl;
    } exp_t;

    typedef struct {
        exp_t e;
        int   due;
        int   tag;
    } sb_t;

    sb_t sbq[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t actual();
        exp_t a;
        a.valid = bus.id_valid;   a.pc = bus.id_pc;
        a.rd = bus.id_rd;         a.rs1 = bus.id_rs1;       a.rs2 = bus.id_rs2;
        a.d1 = bus.id_rs1_data;   a.d2 = bus.id_rs2_data;   a.imm = bus.id_imm;
        a.f3 = bus.id_funct3;     a.op = bus.id_alu_op;
        a.fl = {bus.id_alu_src_imm, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                bus.id_branch, bus.id_jal, bus.id_jalr, bus.id_auipc, bus.id_illegal};
        return a;
    endfunction

    function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                input logic [2:0] f3, input logic [3:0] op, input logic [8:0] fl);
        exp_t e;
        e.valid = v; e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.d1 = d1; e.d2 = d2; e.imm = imm; e.f3 = f3; e.op = op; e.fl = fl;
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t exp);
        exp_t act;
        act = actual();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: compare registered outputs once the due cycle's edge has loaded them
    always @(negedge clk) begin
        sb_t s;
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            s = sbq.pop_front();
            check_out($sformatf("out%0d", s.tag), s.e);
        end
    end

    task automatic step(input int tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic v, input logic fl, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, input logic exp_stall, input exp_t e);
        sb_t s;
        @(posedge clk);
        #1;
        bus.instr_in = ins; bus.pc_in = pc; bus.instr_valid = v; bus.flush = fl;
        bus.wb_en = we;     bus.wb_rd = wrd; bus.wb_data = wd;
        #1;
        check_bit($sformatf("stall%0d", tag), bus.hazard_stall, exp_stall);
        s.e = e; s.due = cyc + 1; s.tag = tag;
        sbq.push_back(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t bub;
        exp_t e_lw;
        bub = '0;
        rst = 1'b0;
        bus.instr_in = '0; bus.pc_in = '0; bus.instr_valid = 1'b0; bus.flush = 1'b0;
        bus.wb_en = 1'b0;  bus.wb_rd = '0; bus.wb_data = '0;
        #1;
        check_out("reset", bub);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // addi x1,x0,5
        step(1, 32'h00500093, 32'h100, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h100, 1, 0, 5, 0, 0, 32'd5, 0, 0, F_IMM | F_RW));
        // add x2,x1,x1 with same-cycle writeback x1=0x1234
        step(2, 32'h00108133, 32'h104, 1, 0, 1, 1, 32'h1234, 0,
             mk(1, 32'h104, 2, 1, 1, 32'h1234, 32'h1234, 0, 0, 0, F_RW));
        // add x7,x0,x0 while writeback targets x0
        step(3, 32'h000003B3, 32'h108, 1, 0, 1, 0, 32'hDEAD, 0,
             mk(1, 32'h108, 7, 0, 0, 0, 0, 0, 0, 0, F_RW));
        // add x4,x1,x0: x1 from the register file now
        step(4, 32'h00008233, 32'h10C, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h10C, 4, 1, 0, 32'h1234, 0, 0, 0, 0, F_RW));
        // lw x5,0(x1)
        e_lw = mk(1, 32'h110, 5, 1, 0, 32'h1234, 0, 0, 3'd2, 0, F_IMM | F_RW | F_MR);
        step(5, 32'h0000A283, 32'h110, 1, 0, 0, 0, 0, 0, e_lw);
        // add x6,x5,x0: load-use stall -> bubble
        step(6, 32'h00028333, 32'h114, 1, 0, 0, 0, 0, 1, bub);
        // re-presented add decodes
        step(7, 32'h00028333, 32'h114, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h114, 6, 5, 0, 0, 0, 0, 0, 0, F_RW));
        // lw again, then flush beats the stall
        e_lw.pc = 32'h118;
        step(8, 32'h0000A283, 32'h118, 1, 0, 0, 0, 0, 0, e_lw);
        step(9, 32'h00028333, 32'h11C, 1, 1, 0, 0, 0, 0, bub);
        // beq x0,x0,-8
        step(10, 32'hFE000CE3, 32'h120, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h120, 25, 0, 0, 0, 0, 32'hFFFFFFF8, 0, 4'd1, F_BR));
        // lui x3,0xABCDE
        step(11, 32'hABCDE1B7, 32'h124, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h124, 3, 27, 28, 0, 0, 32'hABCDE000, 3'd6, 4'd10, F_IMM | F_RW));
        // illegal all-ones
        step(12, 32'hFFFFFFFF, 32'h128, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h128, 31, 31, 31, 0, 0, 0, 3'd7, 0, F_ILL));
        // addi in flight, then async reset between edges
        step(13, 32'h00500093, 32'h12C, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h12C, 1, 0, 5, 0, 0, 32'd5, 0, 0, F_IMM | F_RW));
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.instr_valid = 1'b0;
        check_bit("pre_reset_valid", bus.id_valid, 1'b1);
        rst = 1'b0;
        #1;
        check_out("midreset", bub);
        @(posedge clk);
        #1 rst = 1'b1;
        // add x4,x1,x0: x1 cleared by reset
        step(14, 32'h00008233, 32'h200, 1, 0, 0, 0, 0, 0,
             mk(1, 32'h200, 4, 1, 0, 0, 0, 0, 0, 0, F_RW));
        step(15, 32'h00000000, 32'h204, 0, 0, 0, 0, 0, 0, bub);

        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
